i2s_rx_deserializer: RTL
========================

I2S_RX_DESERIALIZER -- requirements
Module: i2s_rx_deserializer

Interface
REQ-001 Parameter DATA_W, default 24, sample width in bits.
REQ-002 Parameter FIFO_DEPTH, default 4, stereo-pair FIFO depth (power of 2).
REQ-003 Parameter BCK_TIMEOUT, default 255, clk cycles without a bck rise before lock is dropped.
REQ-004 Ports: clk in 1, system clock. One clock; reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 i2s_bck  in  1  I2S bit clock from the S/PDIF decoder, oversampled by clk.
REQ-007 i2s_ws  in  1  word select; 0 = left, 1 = right.
REQ-008 i2s_d0  in  1  serial data, MSB first.
REQ-009 pair_valid  out  1  FIFO head holds a stereo pair.
REQ-010 pair_ready  in  1  consumer accepts the head when pair_valid & pair_ready.
REQ-011 pair_left, pair_right  out  DATA_W each  head pair samples.
REQ-012 fifo_level  out  $clog2(FIFO_DEPTH)+1  stored pairs.
REQ-013 locked  out  1  stream framing valid.
REQ-014 overflow  out  1  sticky; a pair was dropped because the FIFO was full.
REQ-015 frame_err  out  1  one-cycle pulse on a rejected word.

Function
REQ-016 i2s_bck, i2s_ws, i2s_d0 pass through a 2-flop synchronizer; bck_rise = synced bck 0 then 1; ws and d0 are sampled on the clk cycle bck_rise asserts.
REQ-017 States: IDLE, ALIGN, RUN.
- IDLE -> ALIGN after the first bck_rise.
- ALIGN -> RUN on the first bck_rise where sampled ws goes 1 to 0.
- No data is captured in IDLE or ALIGN.
REQ-018 In RUN, each bck_rise writes d0 to sr[DATA_W-1-bitcnt] if bitcnt < DATA_W and increments bitcnt, saturating at 63.
- Bits beyond DATA_W are discarded.
REQ-019 On the bck_rise where sampled ws differs from the previous sampled ws:
- The bit sampled on that rise is the LSB of the finishing word and is stored first.
- The word is then closed, and bitcnt and sr are cleared for the next word.
REQ-020 Words shorter than DATA_W are left-justified, with the unwritten LSBs equal to 0.
REQ-021 A closed word with fewer than 16 bits is rejected:
- frame_err pulses.
- Any held left word is discarded.
- locked is cleared.
- State returns to ALIGN.
REQ-022 A word closed by a ws 0->1 transition is the left sample and is held.
- A word closed by a ws 1->0 transition is the right sample.
- If a left sample is held, {left, right} is pushed to the FIFO one cycle after the close.
- A right sample with no held left sample is dropped without an error.
REQ-023 Pushing to a full FIFO drops the new pair and sets overflow.
- Pushing while a pop occurs on the same cycle is accepted when full.
REQ-024 FIFO outputs are first-word-fall-through, with pair_left/pair_right valid whenever pair_valid is high.
- A pop and a push on the same cycle leave fifo_level unchanged.
REQ-025 locked asserts after 2 consecutive pairs are pushed without a rejected word.
- locked deasserts on frame_err.
- locked deasserts, and the state returns to IDLE, when BCK_TIMEOUT cycles elapse with no bck_rise.
- FIFO contents are preserved when lock is lost.
REQ-026 Latency from the closing bck_rise to pair_valid into an empty FIFO is no more than 2 clk cycles.

Reset
REQ-027 While reset is high on a rising clk, the following are cleared:
- state = IDLE; FIFO emptied; fifo_level = 0.
- pair_valid = 0, locked = 0, overflow = 0, frame_err = 0.
- pair_left = pair_right = 0.
- Synchronizers, sr, bitcnt, held left sample and timeout counter cleared.
REQ-028 Reset asserted mid-word discards the partial word and all FIFO contents; no pair is emitted on the cycle after release.

Structure
REQ-029 Package i2s_rx_pkg holds:
- the state enum;
- DATA_W_DEF = 24;
- MIN_WORD_BITS = 16;
- LOCK_PAIRS = 2.
REQ-030 Sub-module pcm_pair_fifo is a synchronous FWFT FIFO of width 2*DATA_W with push, pop, full, empty and level; all framing logic stays in the parent.

Verification
REQ-031 24-bit I2S stream, left=0xA5A5A5, right=0x123456 -> first pair out equals these values; locked high after the 2nd pair.
REQ-032 20-bit words, left=0xFFFFF, right=0x0000F -> pair_left=0xFFFFF0, pair_right=0x0000F0.
REQ-033 32-bit words, left bits 0xDEADBEEF -> pair_left=0xDEADBE.
REQ-034 pair_ready held low for 6 pairs with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, and popped pairs 1-4 in order.
REQ-035 A 10-bit word injected -> frame_err pulse, locked=0, next valid pair emitted only after a ws 1->0 realignment.
REQ-036 bck stopped for 300 cycles -> locked=0, FIFO contents intact; reset mid-word -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_pkg
//  Description : Shared types and constants for the I2S receive deserializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_rx_pkg;

    // Framing state of the receiver
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    localparam int DATA_W_DEF    = 24;
    localparam int MIN_WORD_BITS = 16;
    localparam int LOCK_PAIRS    = 2;

    // Bit counter increment that sticks at its maximum value
    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcm_pair_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pcm_pair_fifo
//  Description : Synchronous first-word-fall-through FIFO for stereo pairs.
//                Head data is forced to zero while the FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module pcm_pair_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign level_o   = level_q;
    assign w_do_pop  = pop_i & ~empty_o;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push
    assign w_do_push = push_i & (~full_o | w_do_pop);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array; contents are only observable through valid entries
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_rx_deserializer
//  Description : Oversampling I2S receiver. Aligns on ws, assembles left/right
//                words, and queues stereo pairs into a FWFT FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_rx_deserializer
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int BCK_TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i2s_bck,
    input  logic                         i2s_ws,
    input  logic                         i2s_d0,
    output logic                         pair_valid,
    input  logic                         pair_ready,
    output logic [DATA_W-1:0]            pair_left,
    output logic [DATA_W-1:0]            pair_right,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         locked,
    output logic                         overflow,
    output logic                         frame_err
);

    localparam int TO_W = $clog2(BCK_TIMEOUT + 1);

    logic [2:0]          bck_sync_q;
    logic [1:0]          ws_sync_q, d0_sync_q;
    state_e              state_q, state_d;
    logic                ws_prev_q, ws_prev_d;
    logic [DATA_W-1:0]   sr_q, sr_d;
    logic [5:0]          bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]   held_q, held_d;
    logic                held_vld_q, held_vld_d;
    logic                push_q, push_d;
    logic [2*DATA_W-1:0] push_data_q, push_data_d;
    logic                frame_err_q, frame_err_d;
    logic                locked_q, locked_d;
    logic                overflow_q, overflow_d;
    logic [1:0]          pair_cnt_q, pair_cnt_d;
    logic [TO_W-1:0]     to_cnt_q;

    logic                w_bck_rise, w_ws, w_d0, w_timeout;
    logic                w_full, w_empty, w_pop;
    logic [DATA_W-1:0]   w_sr_wr;
    logic [6:0]          w_bits_closed;
    logic [2*DATA_W-1:0] w_head;

    // [1] is the synchronized level, bck [2] is its previous value
    assign w_bck_rise    = bck_sync_q[1] & ~bck_sync_q[2];
    assign w_ws          = ws_sync_q[1];
    assign w_d0          = d0_sync_q[1];
    assign w_timeout     = (to_cnt_q == TO_W'(BCK_TIMEOUT)) && (state_q != ST_IDLE);
    assign w_bits_closed = {1'b0, bitcnt_q} + 7'd1;
    assign w_pop         = pair_valid & pair_ready;

    // Shift register image with the current bit placed at its MSB-first slot
    always_comb begin
        w_sr_wr = sr_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(bitcnt_q) == DATA_W - 1 - i) w_sr_wr[i] = w_d0;
        end
    end

    // Framing, word assembly, pairing and lock tracking
    always_comb begin
        state_d     = state_q;
        ws_prev_d   = ws_prev_q;
        sr_d        = sr_q;
        bitcnt_d    = bitcnt_q;
        held_d      = held_q;
        held_vld_d  = held_vld_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        frame_err_d = 1'b0;
        locked_d    = locked_q;
        pair_cnt_d  = pair_cnt_q;
        overflow_d  = overflow_q | (push_q & w_full & ~w_pop);

        // Count pairs handed to the FIFO since the last rejected word
        if (push_q) begin
            if (pair_cnt_q < 2'(LOCK_PAIRS))       pair_cnt_d = pair_cnt_q + 2'd1;
            if (pair_cnt_q >= 2'(LOCK_PAIRS - 1))  locked_d   = 1'b1;
        end

        if (w_timeout) begin
            state_d    = ST_IDLE;
            locked_d   = 1'b0;
            pair_cnt_d = '0;
            held_vld_d = 1'b0;
            sr_d       = '0;
            bitcnt_d   = '0;
        end else if (w_bck_rise) begin
            ws_prev_d = w_ws;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ALIGN;
                end
                ST_ALIGN: begin
                    sr_d     = '0;
                    bitcnt_d = '0;
                    // The rise carrying the right word's LSB marks a frame start
                    if (ws_prev_q && !w_ws) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (w_ws != ws_prev_q) begin
                        // This rise carries the LSB of the word being closed
                        sr_d     = '0;
                        bitcnt_d = '0;
                        if (w_bits_closed < 7'(MIN_WORD_BITS)) begin
                            frame_err_d = 1'b1;
                            held_vld_d  = 1'b0;
                            locked_d    = 1'b0;
                            pair_cnt_d  = '0;
                            state_d     = ST_ALIGN;
                        end else if (!ws_prev_q) begin
                            held_d     = w_sr_wr;
                            held_vld_d = 1'b1;
                        end else if (held_vld_q) begin
                            push_d      = 1'b1;
                            push_data_d = {held_q, w_sr_wr};
                            held_vld_d  = 1'b0;
                        end
                    end else begin
                        sr_d     = w_sr_wr;
                        bitcnt_d = sat_inc6(bitcnt_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers, synchronizers and bck watchdog
    always_ff @(posedge clk) begin
        if (reset) begin
            bck_sync_q  <= '0;
            ws_sync_q   <= '0;
            d0_sync_q   <= '0;
            state_q     <= ST_IDLE;
            ws_prev_q   <= 1'b0;
            sr_q        <= '0;
            bitcnt_q    <= '0;
            held_q      <= '0;
            held_vld_q  <= 1'b0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            frame_err_q <= 1'b0;
            locked_q    <= 1'b0;
            overflow_q  <= 1'b0;
            pair_cnt_q  <= '0;
            to_cnt_q    <= '0;
        end else begin
            bck_sync_q  <= {bck_sync_q[1:0], i2s_bck};
            ws_sync_q   <= {ws_sync_q[0], i2s_ws};
            d0_sync_q   <= {d0_sync_q[0], i2s_d0};
            state_q     <= state_d;
            ws_prev_q   <= ws_prev_d;
            sr_q        <= sr_d;
            bitcnt_q    <= bitcnt_d;
            held_q      <= held_d;
            held_vld_q  <= held_vld_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            frame_err_q <= frame_err_d;
            locked_q    <= locked_d;
            overflow_q  <= overflow_d;
            pair_cnt_q  <= pair_cnt_d;
            if (w_bck_rise)
                to_cnt_q <= '0;
            else if (to_cnt_q != TO_W'(BCK_TIMEOUT))
                to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    pcm_pair_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_q),
        .push_data_i (push_data_q),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .level_o     (fifo_level)
    );

    assign pair_valid = ~w_empty;
    assign pair_left  = w_head[2*DATA_W-1:DATA_W];
    assign pair_right = w_head[DATA_W-1:0];
    assign locked     = locked_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire
